// File: rtl/spi_pkg.sv
// Shared SPI constants and the responder state encoding.
package spi_pkg;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned CMD_ADDR_W = 7;
    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer for an asynchronous pin: STAGES flop chain, then a
// previous-value flop, with registered one-cycle rise/fall pulses.
// A pin transition shows up as a pulse STAGES+1 cycles later.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Shift the pin through the chain and register edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 responder with an addressable 8-bit register bank.
// Optional macro SPI_REG_TARGET_AUTOINC_EN: address advances after every
// data byte; otherwise the address stays fixed for the whole frame.
module spi_reg_target
    import spi_pkg::*;
#(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic [NREGS*8-1:0]    regs_flat,
    output logic                  wr_stb,
    output logic [CMD_ADDR_W-1:0] wr_addr,
    output logic [SPI_BYTE_W-1:0] wr_data,
    output logic                  frame_active
);

`ifdef SPI_REG_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [7:0] NREGS_W = 8'(NREGS);

    logic sclk_lvl, sclk_rise_raw, sclk_fall_raw, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_lvl;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sclk),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise_raw),
        .fall_o  (sclk_fall_raw)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (cs),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // A pulse whose level has already reverted was a glitch; drop it.
    assign sclk_rise = sclk_rise_raw & sclk_lvl;
    assign sclk_fall = sclk_fall_raw & ~sclk_lvl;

    // MOSI needs only a synchronized level.
    always_ff @(posedge clk) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];

    // After reset the synchronizers hold reset values, not pin samples.
    // Frames are only accepted once the chain has settled and cs has been
    // seen high, so a reset in the middle of a frame ignores its remainder.
    logic [SYNC_STAGES+1:0] settle_q;
    logic                   armed_q;
    logic                   settled;
    assign settled = settle_q[SYNC_STAGES+1];

    // Track synchronizer settling and cs-high arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            settle_q <= {settle_q[SYNC_STAGES:0], 1'b1};
            armed_q  <= armed_q | (settled & cs_lvl);
        end
    end

    spi_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            rx_q, rx_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic                  hold_q, hold_d;
    logic                  rw_q, rw_d;
    logic [CMD_ADDR_W-1:0] addr_q, addr_d;
    logic [SPI_BYTE_W-1:0] regs_q [NREGS];
    logic [SPI_BYTE_W-1:0] regs_d [NREGS];
    logic                  wr_stb_q, wr_stb_d;
    logic [CMD_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [SPI_BYTE_W-1:0] wr_data_q, wr_data_d;

    logic [SPI_BYTE_W-1:0] byte_in;
    logic [CMD_ADDR_W-1:0] next_addr;
    logic [CMD_ADDR_W-1:0] rd_addr;
    logic [SPI_BYTE_W-1:0] rd_data;
    logic                  addr_in_range;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            hold_q    <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            regs_q    <= '{default: '0};
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            hold_q    <= hold_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            regs_q    <= regs_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state, bit shifting, register write and read reload.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        hold_d    = hold_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        regs_d    = regs_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        byte_in       = {rx_q, mosi_lvl};
        next_addr     = AUTOINC ? addr_q + 7'd1 : addr_q;
        addr_in_range = ({1'b0, addr_q} < NREGS_W);
        rd_addr       = (state_q == ST_CMD) ? byte_in[CMD_ADDR_W-1:0] : next_addr;
        rd_data       = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rd_addr == 7'(i)) rd_data = regs_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q && settled) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    hold_d    = 1'b0;
                end
            end
            default: begin
                // cs rise wins over a same-cycle 8th sclk rise: abort, no write.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    tx_d      = '0;
                    hold_d    = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        if (hold_q) hold_d = 1'b0;
                        else        tx_d   = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d      = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            hold_d = 1'b1;
                            if (state_q == ST_CMD) begin
                                state_d = ST_DATA;
                                rw_d    = byte_in[CMD_RW_BIT];
                                addr_d  = byte_in[CMD_ADDR_W-1:0];
                                tx_d    = byte_in[CMD_RW_BIT] ? rd_data : '0;
                            end else begin
                                if (!rw_q && addr_in_range) begin
                                    for (int unsigned i = 0; i < NREGS; i++) begin
                                        if (addr_q == 7'(i)) regs_d[i] = byte_in;
                                    end
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = addr_q;
                                    wr_data_d = byte_in;
                                end
                                addr_d = next_addr;
                                tx_d   = rw_q ? rd_data : '0;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // Flatten the register bank onto the output bus.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_flat[i*8 +: 8] = regs_q[i];
        end
    end

    assign miso         = (state_q != ST_IDLE) ? tx_q[SPI_BYTE_W-1] : 1'b0;
    assign wr_stb       = wr_stb_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target (default NREGS=16, SYNC_STAGES=2).
module tb_spi_reg_target;

    localparam int unsigned NREGS = 16;
    localparam int unsigned HALF  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sclk = 1'b0;
    logic               cs = 1'b1;
    logic               mosi = 1'b0;
    logic               miso;
    logic [NREGS*8-1:0] regs_flat;
    logic               wr_stb;
    logic [6:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               frame_active;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned stb_cnt = 0;
    logic [6:0]  last_addr = '0;
    logic [7:0]  last_data = '0;

    spi_reg_target #(.NREGS(NREGS), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .cs           (cs),
        .mosi         (mosi),
        .miso         (miso),
        .regs_flat    (regs_flat),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    // Count write strobes and remember the strobed address/data.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt   = stb_cnt + 1;
            last_addr = wr_addr;
            last_data = wr_data;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
        rx = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic frame2(input logic [7:0] b0, input logic [7:0] b1,
                          output logic [7:0] r0, output logic [7:0] r1);
        cs_low();
        spi_bits(b0, 8, r0);
        spi_bits(b1, 8, r1);
        cs_high();
    endtask

    initial begin
        logic [7:0]  r0, r1, r2, r3;
        int unsigned stb0;

        repeat (5) @(negedge clk);
        chk("reset_miso", {127'd0, miso}, 128'd0);
        chk("reset_wr_stb", {127'd0, wr_stb}, 128'd0);
        chk("reset_frame_active", {127'd0, frame_active}, 128'd0);
        chk("reset_wr_addr", {121'd0, wr_addr}, 128'd0);
        chk("reset_wr_data", {120'd0, wr_data}, 128'd0);
        chk("reset_regs", regs_flat, 128'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Write 0xA5 to register 5
        stb0 = stb_cnt;
        cs_low();
        chk("frame_active_high", {127'd0, frame_active}, 128'd1);
        spi_bits(8'h05, 8, r0);
        spi_bits(8'hA5, 8, r1);
        cs_high();
        chk("wr_rx0", {120'd0, r0}, 128'h00);
        chk("wr_rx1", {120'd0, r1}, 128'h00);
        chk("wr_stb_count", 128'(stb_cnt - stb0), 128'd1);
        chk("wr_addr", {121'd0, last_addr}, 128'd5);
        chk("wr_data", {120'd0, last_data}, 128'hA5);
        chk("reg5", {120'd0, regs_flat[5*8 +: 8]}, 128'hA5);
        chk("idle_miso", {127'd0, miso}, 128'd0);
        chk("idle_frame_active", {127'd0, frame_active}, 128'd0);

        // Read register 5 back
        stb0 = stb_cnt;
        frame2(8'h85, 8'h00, r0, r1);
        chk("rd_rx0", {120'd0, r0}, 128'h00);
        chk("rd_rx1", {120'd0, r1}, 128'hA5);
        chk("rd_no_stb", 128'(stb_cnt - stb0), 128'd0);

        // Burst starting at register 14
        stb0 = stb_cnt;
        cs_low();
        spi_bits(8'h0E, 8, r0);
        spi_bits(8'h11, 8, r1);
        spi_bits(8'h22, 8, r2);
        spi_bits(8'h33, 8, r3);
        cs_high();
        chk("burst_rx", {96'd0, r0, r1, r2, r3}, 128'h0);
`ifdef SPI_REG_TARGET_AUTOINC_EN
        chk("burst_reg14", {120'd0, regs_flat[14*8 +: 8]}, 128'h11);
        chk("burst_reg15", {120'd0, regs_flat[15*8 +: 8]}, 128'h22);
        chk("burst_stb_count", 128'(stb_cnt - stb0), 128'd2);
`else
        chk("burst_reg14", {120'd0, regs_flat[14*8 +: 8]}, 128'h33);
        chk("burst_reg15", {120'd0, regs_flat[15*8 +: 8]}, 128'h00);
        chk("burst_stb_count", 128'(stb_cnt - stb0), 128'd3);
`endif
        chk("burst_reg5_kept", {120'd0, regs_flat[5*8 +: 8]}, 128'hA5);

        // Out-of-range read and write at address 16
        frame2(8'h90, 8'h00, r0, r1);
        chk("oor_rd_rx1", {120'd0, r1}, 128'h00);
        stb0 = stb_cnt;
        frame2(8'h10, 8'h5A, r0, r1);
        chk("oor_wr_no_stb", 128'(stb_cnt - stb0), 128'd0);
        chk("oor_reg0", {120'd0, regs_flat[7:0]}, 128'h00);

        // Abort: command for reg 3, then half a data byte, then cs high
        stb0 = stb_cnt;
        cs_low();
        spi_bits(8'h03, 8, r0);
        spi_bits(8'hFF, 4, r1);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_fa_before_event", {127'd0, frame_active}, 128'd1);
        @(negedge clk);
        chk("abort_fa_after_event", {127'd0, frame_active}, 128'd0);
        repeat (12) @(negedge clk);
        chk("abort_reg3", {120'd0, regs_flat[3*8 +: 8]}, 128'h00);
        chk("abort_no_stb", 128'(stb_cnt - stb0), 128'd0);
        // Following full frame must start from bit 0
        frame2(8'h03, 8'h3C, r0, r1);
        chk("post_abort_reg3", {120'd0, regs_flat[3*8 +: 8]}, 128'h3C);
        chk("post_abort_addr", {121'd0, last_addr}, 128'd3);

        // Reset during the data byte of a write to register 2
        stb0 = stb_cnt;
        cs_low();
        spi_bits(8'h02, 8, r0);
        spi_bits(8'h7E, 4, r1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_regs", regs_flat, 128'd0);
        spi_bits(8'hE0, 4, r1);
        spi_bits(8'h55, 8, r2);
        chk("midrst_inactive", {127'd0, frame_active}, 128'd0);
        cs_high();
        chk("midrst_regs_after", regs_flat, 128'd0);
        chk("midrst_no_stb", 128'(stb_cnt - stb0), 128'd0);
        frame2(8'h02, 8'h7E, r0, r1);
        chk("midrst_reg2", {120'd0, regs_flat[2*8 +: 8]}, 128'h7E);
        chk("midrst_stb", 128'(stb_cnt - stb0), 128'd1);
        chk("midrst_wr_data", {120'd0, last_data}, 128'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_target.md
# spi_reg_target

SPI responder with an addressable 8-bit register bank, the peripheral end of the team's SPI master link. Operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, with chip select `cs` active low. All SPI pins are oversampled in the system `clk` domain. It decodes a command byte, then writes or reads registers, and presents a write strobe to local logic.

## Interface
- `NREGS`, default 16: number of 8-bit registers, 1..128.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs` and `mosi`, minimum 2.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `sclk` in 1: SPI clock from the master, asynchronous to `clk`.
- `cs` in 1: chip select, active low.
- `mosi` in 1: master-to-target serial data.
- `miso` out 1: target-to-master serial data; driven 0 while `cs` is high (no tristate).
- `regs_flat` out NREGS*8: register contents; register i occupies bits [i*8+7:i*8].
- `wr_stb` out 1: one-cycle pulse when a register is written over SPI.
- `wr_addr` out 7: address of the write; valid while `wr_stb` is high.
- `wr_data` out 8: data of the write; valid while `wr_stb` is high.
- `frame_active` out 1: high while a frame is being serviced (state is not IDLE).

## Operation
- Frame format: byte 0 is the command; bit 7 is RW (1 = read, 0 = write) and bits [6:0] are ADDR. Bytes 1..n are data.
- Write frame: each data byte received on MOSI is written to the current address, and `wr_stb` pulses. MISO returns 0x00 for every byte.
- Read frame: each data byte slot shifts out the register at the current address. MOSI content in those slots is ignored.
- Address range: an address >= NREGS ignores writes (no `wr_stb`) and reads as 0x00. The address is 7 bits and wraps 127 -> 0.
- State machine:
  - IDLE: on a `cs` falling edge, go to CMD.
  - CMD: after 8 bits, latch RW/ADDR and go to DATA. For a read, load the shift register with the register at ADDR.
  - DATA: repeat per byte; after each byte, advance the address and, for a read, reload the shift register.
  - Any state: `cs` high -> IDLE.
- Bit handling: MOSI is sampled on detected rising `sclk`. MISO shifts on detected falling `sclk`, except for the falling edge that follows the 8th rising edge; the freshly loaded byte holds its MSB through that edge.
- Abort: `cs` rising mid-byte discards the partial byte. No write occurs, the state returns to IDLE and the bit counter is cleared.
- Reset values: all registers 0x00, `miso` 0, `wr_stb` 0, `wr_addr` 0, `wr_data` 0, `frame_active` 0, state IDLE. The `cs` synchronizer resets to 1 and the `sclk` synchronizer to 0.
- Reset mid-frame: the target ignores the remainder of the current frame and responds only after `cs` has been seen high and then falling again.

## Timing
- Pin-to-edge latency: a pin transition becomes an edge event SYNC_STAGES+1 `clk` cycles later (3 cycles at the default).
- Write strobe: `wr_stb` is asserted the cycle after the edge event for the 8th rising `sclk` of a data byte. The register updates on the same clock edge that raises `wr_stb`.
- Read data: the MSB of read data is on `miso` within 1 cycle of the 8th-rising-edge event of the preceding byte.
- `sclk` limit: each `sclk` high and low phase must be >= SYNC_STAGES+3 `clk` cycles, i.e. f_sclk <= f_clk/10 at the default. Faster `sclk` is unsupported.
- `cs` setup: `cs` falling must precede the first `sclk` rise by >= SYNC_STAGES+2 `clk` cycles.
- Simultaneous events: a `cs` rise and an 8th `sclk` rise detected in the same cycle are treated as an abort (no write).

## Configuration
- `SPI_REG_TARGET_AUTOINC_EN` defined: the address increments after every data byte, so bursts walk consecutive registers.
- Not defined: the address stays fixed for the whole frame, so repeated data bytes rewrite or re-read the same register.

## Structure
- Shared package `spi_pkg` holds:
  - `CMD_RW_BIT` = 7
  - `CMD_ADDR_W` = 7
  - `SPI_BYTE_W` = 8
  - the state encoding: IDLE, CMD, DATA
- Sub-module `spi_sync_edge`: a SYNC_STAGES flop chain plus a previous-value flop. It outputs the synchronized level and one-cycle rise and fall pulses, and is instanced for `sclk` and `cs`. `mosi` uses the level output only.

## Test plan
- Write: frame 0x05, 0xA5 -> `wr_stb` once with `wr_addr`=5 and `wr_data`=0xA5; register 5 = 0xA5; master receives 0x00, 0x00.
- Read back: after the write above, frame 0x85, 0x00 -> master receives 0x00 then 0xA5; no `wr_stb`.
- Burst with AUTOINC: frame 0x0E, 0x11, 0x22, 0x33 with NREGS=16 -> register 14 = 0x11 and register 15 = 0x22; address 16 is ignored; exactly two `wr_stb` pulses. Without the macro, register 14 = 0x33 and there are three pulses.
- Out of range: frame 0x90, 0x00 -> master receives 0x00 on the data byte; frame 0x10, 0x5A -> no `wr_stb`.
- Abort: frame 0x03 followed by 4 bits of 0xFF, then `cs` high -> register 3 unchanged, no `wr_stb`, `frame_active` low 1 cycle after the `cs` edge event.
- Reset mid-frame: `rst` pulsed during the data byte of a write to address 2 -> all registers 0x00; the rest of the frame is ignored; the next full frame 0x02, 0x7E writes 0x7E to register 2.
